// File: rtl/mac_pe_pipe.sv
// ---------------------------------------------------------------------------
// mac_pe_pipe
//
// Pipelined multiply-accumulate processing element for an output-stationary
// systolic array. The operands pass through east/south forward registers to
// the neighbouring PEs. When both operands are valid their product is
// registered (stage 1) and then added into the accumulator (stage 2). The sum
// can either saturate or wrap, and a sticky overflow flag records that an
// overflow occurred. A drain copies the finished tile result to res_o while
// the next tile is already entering the multiplier.
//
// Parameters
//   IN_WIDTH   operand width of a/b
//   ACC_WIDTH  accumulator/result width (>= 2*IN_WIDTH)
//   SIGNED     1: two's-complement arithmetic, 0: unsigned
//   SATURATE   1: clamp on overflow, 0: wrap modulo 2^ACC_WIDTH
//   RESET_VAL  accumulator value after reset, clear or drain
//
// Ports
//   clk_i, rst_i                 clock (rising edge), async active-high reset
//   a_i/a_valid_i, b_i/b_valid_i west / north operands with valids
//   a_clr_i, b_clr_i             clear the a / b forward register
//   a_o/a_valid_o, b_o/b_valid_o registered operands to east / south
//   acc_clr_i                    discard the accumulation and in-flight product
//   drain_i                      emit the accumulation on res_o and restart
//   acc_o                        live accumulator
//   res_o/res_valid_o            drained result, one-cycle valid pulse
//   ovf_o                        sticky overflow for the current accumulation
// ---------------------------------------------------------------------------
module mac_pe_pipe #(
  parameter int                   IN_WIDTH  = 8,
  parameter int                   ACC_WIDTH = 32,
  parameter bit                   SIGNED    = 1'b1,
  parameter bit                   SATURATE  = 1'b1,
  parameter logic [ACC_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IN_WIDTH-1:0]  a_i,
  input  logic                 a_valid_i,
  input  logic [IN_WIDTH-1:0]  b_i,
  input  logic                 b_valid_i,
  input  logic                 a_clr_i,
  input  logic                 b_clr_i,
  output logic [IN_WIDTH-1:0]  a_o,
  output logic                 a_valid_o,
  output logic [IN_WIDTH-1:0]  b_o,
  output logic                 b_valid_o,
  input  logic                 acc_clr_i,
  input  logic                 drain_i,
  output logic [ACC_WIDTH-1:0] acc_o,
  output logic [ACC_WIDTH-1:0] res_o,
  output logic                 res_valid_o,
  output logic                 ovf_o
);

  localparam int PW = 2 * IN_WIDTH;

  if (ACC_WIDTH < 2 * IN_WIDTH) begin : g_width_chk
    $error("mac_pe_pipe: ACC_WIDTH must be at least 2*IN_WIDTH");
  end

  // Widen a product to the accumulator width, sign- or zero-extending.
  function automatic logic [ACC_WIDTH-1:0] ext_prod(input logic [PW-1:0] p);
    if (SIGNED) return ACC_WIDTH'($signed(p));
    else        return ACC_WIDTH'(p);
  endfunction

  // Add with overflow detection. Returns {overflow, result}; the result is
  // clamped when SATURATE is set, otherwise it is the wrapped sum.
  function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] x,
                                                 input logic [ACC_WIDTH-1:0] y);
    logic [ACC_WIDTH:0]   sum;
    logic                 ovf;
    logic [ACC_WIDTH-1:0] clamp;
    sum = {1'b0, x} + {1'b0, y};
    if (SIGNED) begin
      ovf   = (x[ACC_WIDTH-1] == y[ACC_WIDTH-1]) && (sum[ACC_WIDTH-1] != x[ACC_WIDTH-1]);
      // Both addends share a sign on overflow, so x's sign picks min or max.
      clamp = x[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                             : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      ovf   = sum[ACC_WIDTH];
      clamp = '1;
    end
    return {ovf, (ovf && SATURATE) ? clamp : sum[ACC_WIDTH-1:0]};
  endfunction

  logic                        fire;
  logic signed [PW-1:0]        a_ext, b_ext, prod_d;

  logic [IN_WIDTH-1:0]         a_q, a_d, b_q, b_d;
  logic                        a_v_q, a_v_d, b_v_q, b_v_d;
  logic [PW-1:0]               prod_p1_q;
  logic                        vld_p1_q;
  logic [ACC_WIDTH-1:0]        acc_p2_q, acc_p2_d;
  logic                        ovf_p2_q, ovf_p2_d;
  logic [ACC_WIDTH-1:0]        res_p2_q, res_p2_d;
  logic                        res_v_p2_q, res_v_p2_d;
  logic [ACC_WIDTH:0]          sum_p2;

  assign fire = a_valid_i && b_valid_i;

  // ---- stage 0 -> 1: operand forwarding and multiply ----
  always_comb begin
    if (SIGNED) begin
      a_ext = PW'($signed(a_i));
      b_ext = PW'($signed(b_i));
    end else begin
      a_ext = PW'(a_i);
      b_ext = PW'(b_i);
    end
    // Low PW bits of the extended product are exact in both modes.
    prod_d = a_ext * b_ext;

    a_d   = a_q;
    a_v_d = 1'b0;
    if (a_clr_i) begin
      a_d = '0;
    end else if (a_valid_i) begin
      a_d   = a_i;
      a_v_d = 1'b1;
    end

    b_d   = b_q;
    b_v_d = 1'b0;
    if (b_clr_i) begin
      b_d = '0;
    end else if (b_valid_i) begin
      b_d   = b_i;
      b_v_d = 1'b1;
    end
  end

  // ---- stage 1 -> 2: accumulate, drain, clear ----
  always_comb begin
    sum_p2     = vld_p1_q ? sat_add(acc_p2_q, ext_prod(prod_p1_q)) : {1'b0, acc_p2_q};
    acc_p2_d   = acc_p2_q;
    ovf_p2_d   = ovf_p2_q;
    res_p2_d   = res_p2_q;
    res_v_p2_d = 1'b0;
    if (acc_clr_i) begin
      acc_p2_d = RESET_VAL;
      ovf_p2_d = 1'b0;
    end else if (drain_i) begin
      // The in-flight product belongs to the tile being drained.
      res_p2_d   = sum_p2[ACC_WIDTH-1:0];
      res_v_p2_d = 1'b1;
      acc_p2_d   = RESET_VAL;
      ovf_p2_d   = 1'b0;
    end else begin
      acc_p2_d = sum_p2[ACC_WIDTH-1:0];
      ovf_p2_d = ovf_p2_q | sum_p2[ACC_WIDTH];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q        <= '0;
      a_v_q      <= 1'b0;
      b_q        <= '0;
      b_v_q      <= 1'b0;
      vld_p1_q   <= 1'b0;
      acc_p2_q   <= RESET_VAL;
      ovf_p2_q   <= 1'b0;
      res_p2_q   <= '0;
      res_v_p2_q <= 1'b0;
    end else begin
      a_q        <= a_d;
      a_v_q      <= a_v_d;
      b_q        <= b_d;
      b_v_q      <= b_v_d;
      // A fire in a clear cycle is kept: it starts the new accumulation.
      vld_p1_q   <= fire;
      acc_p2_q   <= acc_p2_d;
      ovf_p2_q   <= ovf_p2_d;
      res_p2_q   <= res_p2_d;
      res_v_p2_q <= res_v_p2_d;
    end
  end

  // Product data is qualified by vld_p1_q and needs no reset.
  always_ff @(posedge clk_i) begin
    if (fire) prod_p1_q <= prod_d;
  end

  assign a_o         = a_q;
  assign a_valid_o   = a_v_q;
  assign b_o         = b_q;
  assign b_valid_o   = b_v_q;
  assign acc_o       = acc_p2_q;
  assign res_o       = res_p2_q;
  assign res_valid_o = res_v_p2_q;
  assign ovf_o       = ovf_p2_q;

endmodule
